// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - multi-stage logic-analyzer trigger with post-trigger capture window
// Steps a small mask/care/offset table against the probe word, then gates the sample buffer.
module trigger_sequencer #(
    parameter int DATA_W = 33,
    parameter int CNT_W  = 17,
    parameter int STAGES = 4,
    localparam int STAGE_W = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [STAGE_W-1:0] cfg_stage,
    input  logic [DATA_W-1:0]  cfg_mask,
    input  logic [DATA_W-1:0]  cfg_care,
    input  logic [CNT_W-1:0]   cfg_offset,
    input  logic [STAGE_W:0]   cfg_nstages,
    input  logic [CNT_W-1:0]   cfg_post,
    input  logic               arm,
    input  logic               abort,
    input  logic [DATA_W-1:0]  data,
    output logic               busy,
    output logic [STAGE_W-1:0] stage,
    output logic               triggered,
    output logic               capture_en,
    output logic               done,
    output logic [7:0]         restarts
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         restarts_q, restarts_d;
    logic [STAGE_W:0]   nstages_q, nstages_d;
    logic [CNT_W-1:0]   post_q, post_d;
    logic               triggered_q, triggered_d;

    logic [DATA_W-1:0]  mask_q   [STAGES];
    logic [DATA_W-1:0]  mask_d   [STAGES];
    logic [DATA_W-1:0]  care_q   [STAGES];
    logic [DATA_W-1:0]  care_d   [STAGES];
    logic [CNT_W-1:0]   offset_q [STAGES];
    logic [CNT_W-1:0]   offset_d [STAGES];

    logic               idle_like;
    logic               arm_ok;
    logic [DATA_W-1:0]  cur_mask;
    logic [DATA_W-1:0]  cur_care;
    logic [CNT_W-1:0]   cur_offset;
    logic               hit;
    logic               miss;
    logic               last_stage;

    assign idle_like  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign arm_ok     = arm && (cfg_nstages != '0) && (int'(cfg_nstages) <= STAGES);
    assign cur_mask   = mask_q[stage_q];
    assign cur_care   = care_q[stage_q];
    assign cur_offset = offset_q[stage_q];
    assign hit        = (((data ^ cur_mask) & cur_care) == '0) &&
                        ((cur_offset == '0) || (cnt_q == cur_offset));
    assign miss       = !hit && (cur_offset != '0) && (cnt_q == cur_offset);
    assign last_stage = ({1'b0, stage_q} == (nstages_q - (STAGE_W+1)'(1)));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            cnt_q       <= '0;
            restarts_q  <= '0;
            nstages_q   <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                mask_q[i]   <= '0;
                care_q[i]   <= '0;
                offset_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            restarts_q  <= restarts_d;
            nstages_q   <= nstages_d;
            post_q      <= post_d;
            triggered_q <= triggered_d;
            for (int i = 0; i < STAGES; i++) begin
                mask_q[i]   <= mask_d[i];
                care_q[i]   <= care_d[i];
                offset_q[i] <= offset_d[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        cnt_d       = cnt_q;
        restarts_d  = restarts_q;
        nstages_d   = nstages_q;
        post_d      = post_q;
        triggered_d = 1'b0;
        mask_d      = mask_q;
        care_d      = care_q;
        offset_d    = offset_q;

        // The table is frozen while a sequence is in flight.
        if (cfg_we && idle_like && (int'(cfg_stage) < STAGES)) begin
            mask_d[cfg_stage]   = cfg_mask;
            care_d[cfg_stage]   = cfg_care;
            offset_d[cfg_stage] = cfg_offset;
        end

        if (abort) begin
            state_d = S_IDLE;
            stage_d = '0;
            cnt_d   = '0;
            post_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_ok) begin
                        state_d    = S_ARMED;
                        stage_d    = '0;
                        cnt_d      = '0;
                        restarts_d = '0;
                        nstages_d  = cfg_nstages;
                        post_d     = cfg_post;
                    end
                end
                S_ARMED: begin
                    if (hit && last_stage) begin
                        triggered_d = 1'b1;
                        state_d     = (post_q == '0) ? S_DONE : S_CAPTURE;
                    end else if (hit) begin
                        stage_d = stage_q + STAGE_W'(1);
                        cnt_d   = '0;
                    end else if (miss) begin
                        stage_d = '0;
                        cnt_d   = '0;
                        if (restarts_q != 8'hFF) begin
                            restarts_d = restarts_q + 8'd1;
                        end
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    // post_q doubles as the remaining-window counter.
                    post_d = post_q - CNT_W'(1);
                    if (post_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state_q == S_ARMED) || (state_q == S_CAPTURE);
        capture_en = (state_q == S_CAPTURE);
        done       = (state_q == S_DONE);
        stage      = stage_q;
        triggered  = triggered_q;
        restarts   = restarts_q;
    end

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb/tb_trigger_sequencer.sv - directed and randomized checks of trigger_sequencer against a behavioural model
module tb_trigger_sequencer;

    localparam int DATA_W = 33;
    localparam int CNT_W  = 17;
    localparam int STAGES = 4;
    localparam int SW     = 2;
    localparam logic [DATA_W-1:0] ALL1 = {DATA_W{1'b1}};

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [SW-1:0]     cfg_stage = '0;
    logic [DATA_W-1:0] cfg_mask = '0;
    logic [DATA_W-1:0] cfg_care = '0;
    logic [CNT_W-1:0]  cfg_offset = '0;
    logic [SW:0]       cfg_nstages = '0;
    logic [CNT_W-1:0]  cfg_post = '0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              busy;
    logic [SW-1:0]     stage;
    logic              triggered;
    logic              capture_en;
    logic              done;
    logic [7:0]        restarts;

    int checks = 0;
    int errors = 0;

    trigger_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .STAGES(STAGES)) dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_stage(cfg_stage),
        .cfg_mask(cfg_mask), .cfg_care(cfg_care), .cfg_offset(cfg_offset),
        .cfg_nstages(cfg_nstages), .cfg_post(cfg_post), .arm(arm), .abort(abort),
        .data(data), .busy(busy), .stage(stage), .triggered(triggered),
        .capture_en(capture_en), .done(done), .restarts(restarts)
    );

    always #5 clock = ~clock;

    // Behavioural model: phase of the capture sequence plus plain integer bookkeeping.
    typedef enum int {M_IDLE, M_ARMED, M_CAP, M_DONE} mmode_t;
    mmode_t            m_mode = M_IDLE;
    int                m_stage, m_wait, m_restarts, m_n, m_post, m_left;
    bit                m_trig;
    logic [DATA_W-1:0] m_mask [STAGES];
    logic [DATA_W-1:0] m_care [STAGES];
    int                m_off  [STAGES];

    task automatic model_step();
        bit hit;
        if (reset) begin
            m_mode = M_IDLE; m_stage = 0; m_wait = 0; m_restarts = 0; m_trig = 0;
            m_n = 0; m_post = 0; m_left = 0;
            for (int i = 0; i < STAGES; i++) begin
                m_mask[i] = '0; m_care[i] = '0; m_off[i] = 0;
            end
            return;
        end
        m_trig = 0;
        if (cfg_we && (m_mode == M_IDLE || m_mode == M_DONE)) begin
            m_mask[cfg_stage] = cfg_mask;
            m_care[cfg_stage] = cfg_care;
            m_off[cfg_stage]  = int'(cfg_offset);
        end
        if (abort) begin
            m_mode = M_IDLE; m_stage = 0;
            return;
        end
        case (m_mode)
            M_IDLE, M_DONE: begin
                if (arm && cfg_nstages >= 1 && cfg_nstages <= STAGES) begin
                    m_mode = M_ARMED; m_stage = 0; m_wait = 0; m_restarts = 0;
                    m_n = int'(cfg_nstages); m_post = int'(cfg_post);
                end
            end
            M_ARMED: begin
                hit = (((data ^ m_mask[m_stage]) & m_care[m_stage]) == '0) &&
                      (m_off[m_stage] == 0 || m_wait == m_off[m_stage]);
                if (hit && m_stage == m_n - 1) begin
                    m_trig = 1;
                    if (m_post == 0) m_mode = M_DONE;
                    else begin m_mode = M_CAP; m_left = m_post; end
                end else if (hit) begin
                    m_stage++; m_wait = 0;
                end else if (m_off[m_stage] != 0 && m_wait == m_off[m_stage]) begin
                    m_stage = 0; m_wait = 0;
                    if (m_restarts < 255) m_restarts++;
                end else if (m_wait < (1 << CNT_W) - 1) begin
                    m_wait++;
                end
            end
            M_CAP: begin
                m_left--;
                if (m_left == 0) m_mode = M_DONE;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_entry(input int k, input logic [DATA_W-1:0] mk, input logic [DATA_W-1:0] ck, input int off);
        cfg_we = 1'b1; cfg_stage = SW'(k); cfg_mask = mk; cfg_care = ck; cfg_offset = CNT_W'(off);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_arm(input int n, input int post);
        cfg_nstages = (SW+1)'(n); cfg_post = CNT_W'(post); arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, stage, triggered, capture_en, done, restarts} !== 13'h0) begin
            errors++;
            $display("FAIL reset_values: got %0h expected 0", {busy, stage, triggered, capture_en, done, restarts});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, stage, triggered, capture_en, done, restarts} !== 13'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got %0h expected 0", {busy, stage, triggered, capture_en, done, restarts});
        end
    endtask

    task automatic test_single_stage();
        int cap, extra;
        write_entry(0, 33'h4, ALL1, 1);
        do_arm(1, 3);
        checks++;
        if ({busy, stage} !== 3'b100) begin
            errors++; $display("FAIL arm_busy: got %b expected 100", {busy, stage});
        end
        data = 33'h0; tick();
        checks++;
        if ({busy, triggered} !== 2'b10) begin
            errors++; $display("FAIL cnt0_no_trig: got %b expected 10", {busy, triggered});
        end
        data = 33'h4; tick();
        checks++;
        if ({triggered, capture_en, done} !== 3'b110) begin
            errors++; $display("FAIL single_trig: got %b expected 110", {triggered, capture_en, done});
        end
        data = 33'h0;
        cap = int'(capture_en); extra = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            cap += int'(capture_en);
            extra += int'(triggered);
        end
        checks++;
        if (cap != 3 || extra != 0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL capture_window: got cap=%0d extra_trig=%0d done=%b busy=%b expected cap=3 extra_trig=0 done=1 busy=0",
                     cap, extra, done, busy);
        end
    endtask

    task automatic test_miss_restart();
        do_arm(1, 3);
        data = 33'h4; tick();
        checks++;
        if ({triggered, restarts} !== 9'h0) begin
            errors++; $display("FAIL early_data: got %0h expected 0", {triggered, restarts});
        end
        data = 33'h0; tick();
        checks++;
        if ({busy, stage, triggered, restarts} !== {1'b1, 2'd0, 1'b0, 8'd1}) begin
            errors++; $display("FAIL miss_restart: got %0h expected %0h", {busy, stage, triggered, restarts}, {1'b1, 2'd0, 1'b0, 8'd1});
        end
        data = 33'h0; tick();
        data = 33'h4; tick();
        checks++;
        if (triggered !== 1'b1) begin
            errors++; $display("FAIL retry_trig: got %b expected 1", triggered);
        end
        data = 33'h0;
        for (int i = 0; i < 20 && !done; i++) tick();
        checks++;
        if (done !== 1'b1 || restarts !== 8'd1) begin
            errors++; $display("FAIL miss_done: got done=%b restarts=%0d expected done=1 restarts=1", done, restarts);
        end
    endtask

    task automatic test_two_stage();
        write_entry(0, 33'hA0, 33'hF0, 0);
        write_entry(1, 33'h5, 33'hF, 2);
        do_arm(2, 2);
        data = 33'h3; tick();
        checks++;
        if (stage !== 2'd0) begin
            errors++; $display("FAIL two_stage_hold: got %0d expected 0", stage);
        end
        data = 33'hAF; tick();
        checks++;
        if (stage !== 2'd1) begin
            errors++; $display("FAIL two_stage_adv: got %0d expected 1", stage);
        end
        data = 33'h0; tick();
        data = 33'h0; tick();
        data = 33'h5; tick();
        checks++;
        if ({triggered, stage} !== 3'b101) begin
            errors++; $display("FAIL two_stage_trig: got %b expected 101", {triggered, stage});
        end
        data = 33'h0;
        for (int i = 0; i < 20 && !done; i++) tick();
        do_arm(2, 2);
        data = 33'hAF; tick();
        data = 33'h0; tick();
        data = 33'h5; tick();
        checks++;
        if ({triggered, stage} !== 3'b001) begin
            errors++; $display("FAIL early_offset: got %b expected 001", {triggered, stage});
        end
        data = 33'h0; tick();
        checks++;
        if ({triggered, stage, restarts} !== {1'b0, 2'd0, 8'd1}) begin
            errors++; $display("FAIL stage1_miss: got %0h expected %0h", {triggered, stage, restarts}, {1'b0, 2'd0, 8'd1});
        end
        do_abort();
        checks++;
        if ({busy, done, restarts} !== {1'b0, 1'b0, 8'd1}) begin
            errors++; $display("FAIL abort_holds_restarts: got %0h expected %0h", {busy, done, restarts}, {1'b0, 1'b0, 8'd1});
        end
    endtask

    task automatic test_abort();
        int cap;
        write_entry(0, 33'h0, 33'h0, 0);
        do_arm(1, 10);
        data = 33'h1; tick();
        checks++;
        if ({triggered, capture_en} !== 2'b11) begin
            errors++; $display("FAIL abort_setup: got %b expected 11", {triggered, capture_en});
        end
        cap = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cap += int'(capture_en);
        end
        checks++;
        if (cap != 4) begin
            errors++; $display("FAIL capture_before_abort: got %0d expected 4", cap);
        end
        do_abort();
        checks++;
        if ({busy, stage, triggered, capture_en, done} !== 6'h0) begin
            errors++; $display("FAIL abort_capture: got %b expected 000000", {busy, stage, triggered, capture_en, done});
        end
        cfg_nstages = 3'd1; cfg_post = '0; arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL abort_beats_arm: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_cfg_while_armed();
        write_entry(0, 33'h12, ALL1, 0);
        do_arm(1, 0);
        data = 33'h0;
        write_entry(0, 33'h34, ALL1, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_during_cfg: got %b expected 1", busy);
        end
        data = 33'h34; tick();
        checks++;
        if (triggered !== 1'b0) begin
            errors++; $display("FAIL cfg_ignored_new: got %b expected 0", triggered);
        end
        data = 33'h12; tick();
        checks++;
        if ({triggered, done, capture_en, busy} !== 4'b1100) begin
            errors++; $display("FAIL post0_trig: got %b expected 1100", {triggered, done, capture_en, busy});
        end
        do_abort();
        do_arm(0, 0);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL nstages0_ignored: got %b expected 00", {busy, done});
        end
        do_arm(5, 0);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL nstages5_ignored: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_saturation();
        write_entry(0, 33'h0, ALL1, 1);
        do_arm(1, 0);
        data = 33'h1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (i == 19) begin
                checks++;
                if (restarts !== 8'd10) begin
                    errors++; $display("FAIL restarts_count: got %0d expected 10", restarts);
                end
            end
        end
        checks++;
        if ({busy, triggered, restarts} !== {1'b1, 1'b0, 8'd255}) begin
            errors++; $display("FAIL restarts_saturate: got busy=%b trig=%b restarts=%0d expected busy=1 trig=0 restarts=255",
                               busy, triggered, restarts);
        end
        reset = 1'b1; arm = 1'b1; cfg_we = 1'b1;
        tick();
        reset = 1'b0; arm = 1'b0; cfg_we = 1'b0;
        checks++;
        if ({busy, stage, triggered, capture_en, done, restarts} !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid_armed: got %0h expected 0", {busy, stage, triggered, capture_en, done, restarts});
        end
        do_arm(1, 0);
        data = 33'h1; tick();
        checks++;
        if ({triggered, done} !== 2'b11) begin
            errors++; $display("FAIL table_cleared: got %b expected 11", {triggered, done});
        end
    endtask

    task automatic test_random();
        logic [12:0] got, exp;
        int shown;
        shown = 0;
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 499) == 0);
            abort       = ($urandom_range(0, 79) == 0);
            arm         = ($urandom_range(0, 9) == 0);
            cfg_we      = ($urandom_range(0, 4) == 0);
            cfg_stage   = SW'($urandom);
            cfg_mask    = '0; cfg_mask[3:0] = 4'($urandom); cfg_mask[32] = 1'($urandom);
            cfg_care    = '0; cfg_care[3:0] = 4'($urandom); cfg_care[32] = 1'($urandom);
            cfg_offset  = CNT_W'($urandom_range(0, 3));
            cfg_nstages = (SW+1)'($urandom_range(0, 5));
            cfg_post    = CNT_W'($urandom_range(0, 4));
            data        = '0; data[3:0] = 4'($urandom); data[32] = 1'($urandom);
            tick();
            got = {busy, stage, triggered, capture_en, done, restarts};
            exp = {(m_mode == M_ARMED || m_mode == M_CAP), SW'(m_stage), m_trig,
                   (m_mode == M_CAP), (m_mode == M_DONE), 8'(m_restarts)};
            checks++;
            if (got !== exp) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_cycle_%0d: got %b expected %b", c, got, exp);
                end
            end
        end
        reset = 1'b0; abort = 1'b0; arm = 1'b0; cfg_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_stage();
        test_miss_restart();
        test_two_stage();
        test_abort();
        test_cfg_while_armed();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Multi-stage trigger controller for the logic-analyzer capture path. Holds a small table of per-stage match conditions (mask, care bits, cycle offset), steps through them against the sampled probe word, and on final-stage match raises a one-cycle trigger pulse followed by a programmable post-trigger capture-enable window. It sits between the host configuration/control registers and the sample buffer write enable, replacing the single-condition offset/mask comparator.

## Interface
- DATA_W, 33: probe word width
- CNT_W, 17: stage-offset and post-trigger counter width
- STAGES, 4: number of stage table entries (2..8)
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- cfg_we  in  1  write stage table entry / global config
- cfg_stage  in  clog2(STAGES)  entry index for cfg_we
- cfg_mask  in  DATA_W  match value for entry
- cfg_care  in  DATA_W  per-bit compare enable (0 = don't care)
- cfg_offset  in  CNT_W  match cycle within stage (0 = any cycle)
- cfg_nstages  in  clog2(STAGES)+1  number of active stages, latched on arm
- cfg_post  in  CNT_W  post-trigger capture length, latched on arm
- arm  in  1  start sequencing (pulse)
- abort  in  1  return to IDLE (pulse)
- data  in  DATA_W  sampled probe word
- busy  out  1  state is ARMED or CAPTURE
- stage  out  clog2(STAGES)  current stage index
- triggered  out  1  one-cycle pulse on final-stage match
- capture_en  out  1  sample buffer write enable
- done  out  1  high in DONE until next arm/reset
- restarts  out  8  count of stage-miss restarts since arm, saturating at 255

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- Match in stage k: ((data ^ mask[k]) & care[k]) == 0, and (offset[k] == 0 or cnt == offset[k]); cnt is cycles since entering stage k, 0 on the entry cycle.
- IDLE: cfg_we writes entry cfg_stage; cfg_nstages == 0 or > STAGES on arm → arm ignored. arm → ARMED, stage=0, cnt=0, restarts=0, nstages/post latched.
- ARMED, match, k < nstages-1: stage←k+1, cnt←0.
- ARMED, match, k == nstages-1: triggered=1 next cycle; post==0 → DONE, else → CAPTURE with post counter = post.
- ARMED, no match, offset[k] != 0 and cnt == offset[k] (miss): stage←0, cnt←0, restarts+1 (saturating). Otherwise cnt+1.
- offset[k]==0 stages wait indefinitely; cnt saturates at all-ones.
- CAPTURE: capture_en=1 for exactly post cycles, then DONE.
- DONE: done=1; arm → ARMED (as from IDLE); cfg_we accepted.
- cfg_we while busy: ignored, table unchanged.
- abort in any state → IDLE next cycle, all outputs cleared except restarts (held). abort beats arm on same cycle.
- arm while busy: ignored.

## Timing
- Reset values: state IDLE, stage 0, busy 0, triggered 0, capture_en 0, done 0, restarts 0; table entries cleared (mask 0, care 0, offset 0).
- All outputs registered. data compared combinationally in the cycle it is presented; effect visible on outputs next edge.
- arm at edge N → busy=1 after N; first data compared is the cycle after N (cnt=0).
- Final match sampled at edge M → triggered=1 and, if post>0, capture_en=1 during cycle after M; capture_en high cycles M+1..M+post; done=1 from M+post+1.
- post==0: triggered at M+1 together with done=1; capture_en never asserts.
- Stage advance: stage output updates one cycle after the matching sample; the new stage's cnt=0 sample is the next data word.
- Reset mid-operation overrides abort/arm/cfg_we.

## Test plan
- Single stage, mask=4, care=all-ones, offset=1, post=3; arm, data=4 on second armed cycle → triggered one cycle later, capture_en exactly 3 cycles, then done=1.
- Same config, data=4 on first armed cycle only, then 0 → miss at cnt=1, restarts=1, stage stays 0, no trigger; data=4 at next cnt=1 → trigger.
- Two stages: stage0 mask=0xA0 care=0xF0 offset=0, stage1 mask=0x5 care=0xF offset=2; data 0x3, 0xAF, 0x0, 0x0, 0x5 → stage=1 after 0xAF, trigger on the 0x5 (cnt=2); 0x5 at cnt=1 instead → restart to stage 0.
- abort during CAPTURE (post=10, abort after 4 cycles) → capture_en drops next cycle, state IDLE, done=0; arm and abort same cycle in IDLE → stays IDLE.
- cfg_we while ARMED changing stage0 mask → ignored, original mask still triggers; nstages=0 arm → stays IDLE, busy=0.
- 300 consecutive misses → restarts saturates at 255; reset mid-ARMED → all outputs to reset values next edge.
